// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 driver and its poller: state codes,
// 50 MHz timing constants and the sensor's plausible integer ranges.
package dht11_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    START       = 4'd1,
    ARM         = 4'd2,
    WAIT_RESULT = 4'd3,
    VALIDATE    = 4'd4,
    UPDATE      = 4'd5,
    RETRY_CHK   = 4'd6,
    RETRY_WAIT  = 4'd7,
    PERIOD_WAIT = 4'd8
  } estado_t;

  localparam int CICLOS_1S  = 50_000_000;
  localparam int CICLOS_1MS = 50_000;

  localparam logic [7:0] UMID_MAX = 8'd100;
  localparam logic [7:0] TEMP_MAX = 8'd60;

  function automatic logic leitura_valida(input logic [7:0] umid, input logic [7:0] temp);
    return (umid <= UMID_MAX) && (temp <= TEMP_MAX);
  endfunction

endpackage

// File: rtl/dht11_poller.sv
// Measurement sequencer above dht11: periodic or manual reads with retries,
// range check, and a latched reading plus alarms that update on one edge.
module dht11_poller
  import dht11_pkg::*;
#(
  parameter int PERIODO         = 2 * CICLOS_1S,
  parameter int TIMEOUT         = 50 * CICLOS_1MS,
  parameter int INTERVALO_RETRY = CICLOS_1S,
  parameter int MAX_TENTATIVAS  = 3,
  parameter int TEMP_LIMITE     = 30,
  parameter int UMID_LIMITE     = 80
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        request,
  output logic        dht_start,
  input  logic        dht_pronto,
  input  logic        dht_error,
  input  logic [15:0] dht_temperatura,
  input  logic [15:0] dht_umidade,
  output logic [7:0]  temperatura,
  output logic [7:0]  umidade,
  output logic        valido,
  output logic        falha,
  output logic        alarme_temp,
  output logic        alarme_umid,
  output logic [7:0]  leituras,
  output logic [3:0]  db_estado
);

  localparam int PW = $clog2(PERIODO);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(INTERVALO_RETRY);

  localparam logic [PW-1:0] PER_FIM  = PW'(PERIODO - 1);
  localparam logic [TW-1:0] TO_FIM   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RT_FIM   = RW'(INTERVALO_RETRY - 1);
  localparam logic [3:0]    MAX_T    = 4'(MAX_TENTATIVAS);
  localparam logic [7:0]    TEMP_LIM = 8'(TEMP_LIMITE);
  localparam logic [7:0]    UMID_LIM = 8'(UMID_LIMITE);

  estado_t       estado, prox;
  logic [PW-1:0] cnt_per;
  logic [TW-1:0] cnt_to;
  logic [RW-1:0] cnt_rt;
  logic [3:0]    tentativas;

  logic per_clr, tent_clr, tent_inc, to_clr, rt_clr, atualiza, esgotou;

  // Fraction bytes are delivered by dht11 but only integer parts are published.
  logic unused_frac;
  assign unused_frac = ^{dht_temperatura[7:0], dht_umidade[7:0]};

  assign db_estado = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= prox;
  end

  always_comb begin
    prox     = estado;
    per_clr  = 1'b0;
    tent_clr = 1'b0;
    tent_inc = 1'b0;
    to_clr   = 1'b0;
    rt_clr   = 1'b0;
    atualiza = 1'b0;
    esgotou  = 1'b0;
    case (estado)
      IDLE: if (enable || request) begin
        per_clr  = 1'b1;
        tent_clr = 1'b1;
        prox     = START;
      end
      START: begin
        tent_inc = 1'b1;
        prox     = ARM;
      end
      // dht11 still shows the previous result here, so it is not looked at.
      ARM: begin
        to_clr = 1'b1;
        prox   = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (dht_error)             prox = RETRY_CHK;
        else if (dht_pronto)       prox = VALIDATE;
        else if (cnt_to == TO_FIM) prox = RETRY_CHK;
      end
      VALIDATE: prox = leitura_valida(dht_umidade[15:8], dht_temperatura[15:8]) ? UPDATE : RETRY_CHK;
      UPDATE: begin
        atualiza = 1'b1;
        prox     = PERIOD_WAIT;
      end
      RETRY_CHK: begin
        rt_clr = 1'b1;
        if (tentativas < MAX_T) prox = RETRY_WAIT;
        else begin
          esgotou = 1'b1;
          prox    = PERIOD_WAIT;
        end
      end
      RETRY_WAIT: if (cnt_rt == RT_FIM) prox = START;
      // Counter saturates, so a cycle whose retries overran the period restarts at once.
      PERIOD_WAIT: if (cnt_per == PER_FIM) begin
        if (enable) begin
          per_clr  = 1'b1;
          tent_clr = 1'b1;
          prox     = START;
        end else begin
          prox = IDLE;
        end
      end
      default: prox = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_per    <= '0;
      cnt_to     <= '0;
      cnt_rt     <= '0;
      tentativas <= '0;
      dht_start  <= 1'b0;
    end else begin
      dht_start <= (prox == START);
      if (per_clr)                                   cnt_per <= '0;
      else if (estado != IDLE && cnt_per != PER_FIM) cnt_per <= cnt_per + 1'b1;
      if (to_clr)                     cnt_to <= '0;
      else if (estado == WAIT_RESULT) cnt_to <= cnt_to + 1'b1;
      if (rt_clr)                    cnt_rt <= '0;
      else if (estado == RETRY_WAIT) cnt_rt <= cnt_rt + 1'b1;
      if (tent_clr)      tentativas <= '0;
      else if (tent_inc) tentativas <= tentativas + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      temperatura <= '0;
      umidade     <= '0;
      valido      <= 1'b0;
      falha       <= 1'b0;
      alarme_temp <= 1'b0;
      alarme_umid <= 1'b0;
      leituras    <= '0;
    end else if (atualiza) begin
      temperatura <= dht_temperatura[15:8];
      umidade     <= dht_umidade[15:8];
      valido      <= 1'b1;
      falha       <= 1'b0;
      alarme_temp <= dht_temperatura[15:8] >= TEMP_LIM;
      alarme_umid <= dht_umidade[15:8] >= UMID_LIM;
      leituras    <= leituras + 8'd1;
    end else if (esgotou) begin
      falha <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_poller.sv
// Randomized bench for dht11_poller: behavioural dht11 responder plus a
// schedule/scoreboard model of when starts happen and what gets published.
module tb_dht11_poller;

  localparam int PER = 200;
  localparam int TO  = 50;
  localparam int RI  = 20;
  localparam int MT  = 3;

  localparam int K_OK   = 0;
  localparam int K_BAD  = 1;
  localparam int K_ERR  = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int          kind;
    int          dly;
    logic [15:0] hum;
    logic [15:0] tmp;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        request = 1'b0;
  logic        dht_start;
  logic        dht_pronto = 1'b0;
  logic        dht_error = 1'b0;
  logic [15:0] dht_temperatura = '0;
  logic [15:0] dht_umidade = '0;
  logic [7:0]  temperatura, umidade, leituras;
  logic        valido, falha, alarme_temp, alarme_umid;
  logic [3:0]  db_estado;

  dht11_poller #(
    .PERIODO(PER), .TIMEOUT(TO), .INTERVALO_RETRY(RI), .MAX_TENTATIVAS(MT),
    .TEMP_LIMITE(30), .UMID_LIMITE(80)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .request(request),
    .dht_start(dht_start), .dht_pronto(dht_pronto), .dht_error(dht_error),
    .dht_temperatura(dht_temperatura), .dht_umidade(dht_umidade),
    .temperatura(temperatura), .umidade(umidade), .valido(valido), .falha(falha),
    .alarme_temp(alarme_temp), .alarme_umid(alarme_umid),
    .leituras(leituras), .db_estado(db_estado)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // dht11 stand-in: flags clear two cycles after start is seen and the
  // response appears dly cycles later, data held until the next start.
  resp_t rq[$];
  int    starts[$];
  int    rd = 0;
  resp_t cur;
  int    clr_at = -1;
  int    fire_at = -1;
  always @(negedge clock) begin
    if (dht_start) begin
      starts.push_back(cyc);
      clr_at <= cyc + 2;
      if (rd < rq.size()) begin
        cur     <= rq[rd];
        fire_at <= (rq[rd].kind == K_NONE) ? -1 : cyc + 2 + rq[rd].dly;
        rd      <= rd + 1;
      end else begin
        fire_at <= -1;
      end
    end
    if (cyc == clr_at) begin
      dht_pronto <= 1'b0;
      dht_error  <= 1'b0;
    end
    if (cyc == fire_at) begin
      if (cur.kind == K_ERR) dht_error <= 1'b1;
      else begin
        dht_pronto      <= 1'b1;
        dht_umidade     <= cur.hum;
        dht_temperatura <= cur.tmp;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int e_t = 0, e_h = 0, e_leit = 0;
  bit e_val = 1'b0, e_fal = 1'b0;

  task automatic chk_outs(input string tag);
    chk({tag, ".temperatura"}, temperatura, e_t);
    chk({tag, ".umidade"}, umidade, e_h);
    chk({tag, ".valido"}, valido, e_val);
    chk({tag, ".falha"}, falha, e_fal);
    chk({tag, ".alarme_temp"}, alarme_temp, (e_t >= 30));
    chk({tag, ".alarme_umid"}, alarme_umid, (e_h >= 80));
    chk({tag, ".leituras"}, leituras, e_leit);
  endtask

  function automatic resp_t mk(input int kind, input int dly, input logic [15:0] hum, input logic [15:0] tmp);
    resp_t r;
    r.kind = kind; r.dly = dly; r.hum = hum; r.tmp = tmp;
    return r;
  endfunction

  function automatic resp_t rnd_resp(input int kind);
    resp_t r;
    r.kind = kind;
    r.dly  = $urandom_range(1, 20);
    r.hum  = {8'($urandom_range(0, 100)), 8'($urandom)};
    r.tmp  = {8'($urandom_range(0, 60)), 8'($urandom)};
    if ($urandom_range(0, 3) == 0) r.hum[15:8] = 8'd100;
    if ($urandom_range(0, 3) == 0) r.tmp[15:8] = 8'd60;
    if (kind == K_BAD) begin
      if ($urandom_range(0, 1) == 1) r.hum[15:8] = 8'($urandom_range(101, 255));
      else                           r.tmp[15:8] = 8'($urandom_range(61, 255));
    end
    return r;
  endfunction

  // A successful reading is published three cycles after pronto is seen.
  task automatic apply_ok(input resp_t r);
    e_t    = int'(r.tmp[15:8]);
    e_h    = int'(r.hum[15:8]);
    e_val  = 1'b1;
    e_fal  = 1'b0;
    e_leit = (e_leit + 1) % 256;
  endtask

  resp_t plan[$];

  // Runs every measurement cycle in plan (each ends at a good read or after
  // MT attempts); periodic uses enable, otherwise a single request pulse.
  task automatic run(input bit periodic);
    int n0, t, s, c0, k, r, p, last_c0, idle_at, ei;
    int exp_st[$];
    int ev_cyc[$];
    int ev_i[$];
    n0 = starts.size();
    foreach (plan[i]) rq.push_back(plan[i]);
    @(negedge clock);
    t = cyc;
    if (periodic) enable = 1'b1;
    else          request = 1'b1;
    c0 = t + 1; s = c0; k = 0; last_c0 = c0; p = c0;
    foreach (plan[i]) begin
      exp_st.push_back(s);
      k++;
      r = s + 2 + plan[i].dly;
      case (plan[i].kind)
        K_OK:    begin p = r + 3; ev_cyc.push_back(p); ev_i.push_back(i); end
        K_BAD:   begin p = r + 3; s = r + 3 + RI; end
        K_ERR:   begin p = r + 2; s = r + 2 + RI; end
        default: begin p = s + 3 + TO; s = s + 3 + TO + RI; end
      endcase
      if (plan[i].kind == K_OK || k == MT) begin
        if (plan[i].kind != K_OK) begin ev_cyc.push_back(p); ev_i.push_back(-1); end
        last_c0 = c0;
        c0 = (p + 1 > c0 + PER) ? p + 1 : c0 + PER;
        s = c0; k = 0;
      end
    end
    idle_at = c0;
    ei = 0;
    while (cyc < idle_at) begin
      @(negedge clock);
      request = (cyc == t + 5);
      if (periodic && cyc == last_c0 + 10) enable = 1'b0;
      if (ei < ev_cyc.size()) begin
        if (cyc == ev_cyc[ei] - 1) chk_outs("hold");
        else if (cyc == ev_cyc[ei]) begin
          if (ev_i[ei] >= 0) apply_ok(plan[ev_i[ei]]);
          else               e_fal = 1'b1;
          chk_outs("upd");
          ei++;
        end
      end
      if (cyc == idle_at - 1) chk("period_wait_state", db_estado, 8);
    end
    chk("idle_state", db_estado, 0);
    chk("n_starts", starts.size() - n0, exp_st.size());
    foreach (exp_st[i])
      if (n0 + i < starts.size()) chk("start_cycle", starts[n0 + i], exp_st[i]);
    chk_outs("end");
  endtask

  initial begin
    int kd;
    int kind;
    int t;

    @(negedge clock);
    chk("rst_state", db_estado, 0);
    chk("rst_start", dht_start, 0);
    chk_outs("rst");
    reset = 1'b0;

    plan.delete();
    plan.push_back(mk(K_OK, 8, 16'h3700, 16'h1900));
    run(1'b0);
    chk("t1_umidade", umidade, 55);
    chk("t1_temperatura", temperatura, 25);
    chk("t1_valido", valido, 1);
    chk("t1_leituras", leituras, 1);
    chk("t1_alarmes", {alarme_temp, alarme_umid}, 0);

    plan.delete();
    plan.push_back(mk(K_ERR, 3, 16'h0, 16'h0));
    plan.push_back(mk(K_ERR, 4, 16'h0, 16'h0));
    plan.push_back(mk(K_OK, 5, 16'h4012, 16'h1534));
    run(1'b0);

    plan.delete();
    for (int i = 0; i < MT; i++) plan.push_back(mk(K_NONE, 1, 16'h0, 16'h0));
    run(1'b0);
    chk("timeout_falha", falha, 1);
    chk("timeout_valido", valido, 1);

    plan.delete();
    plan.push_back(mk(K_BAD, 6, 16'h6500, 16'h1400));
    plan.push_back(mk(K_OK, 9, 16'h3C00, 16'h1600));
    run(1'b0);

    plan.delete();
    plan.push_back(mk(K_OK, 5, 16'h2000, 16'h1E00));
    for (int i = 0; i < MT; i++) plan.push_back(mk(K_NONE, 1, 16'h0, 16'h0));
    plan.push_back(mk(K_OK, 7, 16'h5000, 16'h1D00));
    run(1'b1);
    chk("per_alarme_umid_eq", alarme_umid, 1);
    chk("per_alarme_temp", alarme_temp, 0);

    for (int c = 0; c < 20; c++) begin
      plan.delete();
      for (int k = 0; k < MT; k++) begin
        kd = $urandom_range(0, 4);
        kind = (kd <= 1) ? K_OK : kd - 1;
        plan.push_back(rnd_resp(kind));
        if (kind == K_OK) break;
      end
      run(1'b0);
    end

    rq.push_back(mk(K_NONE, 1, 16'h0, 16'h0));
    @(negedge clock);
    t = cyc;
    request = 1'b1;
    while (cyc < t + 10) begin
      @(negedge clock);
      request = 1'b0;
    end
    chk("pre_rst_wait_state", db_estado, 3);
    #3 reset = 1'b1;
    #2;
    e_t = 0; e_h = 0; e_leit = 0; e_val = 1'b0; e_fal = 1'b0;
    chk("async_rst_state", db_estado, 0);
    chk("async_rst_start", dht_start, 0);
    chk_outs("async_rst");
    @(negedge clock);
    reset = 1'b0;

    plan.delete();
    for (int i = 0; i < 256; i++) plan.push_back(rnd_resp(K_OK));
    run(1'b1);
    chk("leituras_wrap", leituras, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
